// File: rtl/sha256_pkg.sv
// Shared constants and FSM encoding for the SHA-256 message feeder.
package sha256_pkg;

  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_STATE_W = 256;

  localparam logic [SHA256_STATE_W-1:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [SHA256_STATE_W-1:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_PAD  = 3'd2,
    ST_LOAD = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/sha256_msg_feeder.sv
// SHA-256 padding front end: packs a 32-bit word stream into 512-bit blocks and
// sequences sha256_core. Optional SHA-224 IV select via SHA256_FEEDER_SHA224_EN.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int IV_SEL_W = 1
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      start_i,
`ifdef SHA256_FEEDER_SHA224_EN
  input  logic [IV_SEL_W-1:0]       mode_i,
`endif
  input  logic [31:0]               data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  input  logic [2:0]                bytes_i,
  output logic                      ready_o,
  output logic                      core_load_o,
  output logic [SHA256_BLOCK_W-1:0] core_data_o,
  output logic [SHA256_STATE_W-1:0] core_state_o,
  input  logic [SHA256_STATE_W-1:0] core_state_i,
  input  logic                      core_busy_i,
  output logic [SHA256_STATE_W-1:0] digest_o,
  output logic                      done_o,
  output logic                      busy_o
);

  feeder_state_e             state_q, state_d;
  logic [4:0]                idx_q, idx_d;
  logic [31:0]               blk_q [16];
  logic [31:0]               blk_d [16];
  logic [SHA256_STATE_W-1:0] chain_q, chain_d;
  logic [SHA256_STATE_W-1:0] digest_q, digest_d;
  logic [63:0]               cnt_q, cnt_d;
  logic                      marker_q, marker_d;
  logic                      len_hi_q, len_hi_d;
  logic                      len_done_q, len_done_d;
  logic                      pad_pending_q, pad_pending_d;
  logic                      done_q, done_d;

  logic [31:0]               fill_word;
  logic [SHA256_STATE_W-1:0] iv_sel;
  logic [SHA256_STATE_W-1:0] final_digest;

`ifdef SHA256_FEEDER_SHA224_EN
  assign iv_sel       = (mode_i == IV_SEL_W'(1)) ? IV224 : IV256;
  assign final_digest = {core_state_i[SHA256_STATE_W-1:32], 32'h0};
`else
  assign iv_sel       = IV256;
  assign final_digest = core_state_i;
`endif

  // Incoming word with unused low bytes cleared and, on a short last word,
  // the 0x80 marker dropped into the first free byte.
  always_comb begin
    case (bytes_i)
      3'd0:    fill_word = 32'h0;
      3'd1:    fill_word = {data_i[31:24], 24'h0};
      3'd2:    fill_word = {data_i[31:16], 16'h0};
      3'd3:    fill_word = {data_i[31:8], 8'h0};
      default: fill_word = data_i;
    endcase
    if (last_i) begin
      case (bytes_i)
        3'd0:    fill_word[31:24] = 8'h80;
        3'd1:    fill_word[23:16] = 8'h80;
        3'd2:    fill_word[15:8]  = 8'h80;
        3'd3:    fill_word[7:0]   = 8'h80;
        default: ;
      endcase
    end
  end

  assign ready_o     = (state_q == ST_FILL) && (idx_q < 5'd16);
  // The core has no reset, so a load must not leak through during rst_i.
  assign core_load_o = (state_q == ST_LOAD) && !rst_i;
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o      = done_q;
  assign digest_o    = digest_q;
  assign core_state_o = chain_q;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      core_data_o[SHA256_BLOCK_W-1-32*i -: 32] = blk_q[i];
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    state_d       = state_q;
    idx_d         = idx_q;
    blk_d         = blk_q;
    chain_d       = chain_q;
    digest_d      = digest_q;
    cnt_d         = cnt_q;
    marker_d      = marker_q;
    len_hi_d      = len_hi_q;
    len_done_d    = len_done_q;
    pad_pending_d = pad_pending_q;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i && !core_busy_i) begin
          chain_d       = iv_sel;
          digest_d      = '0;
          idx_d         = '0;
          cnt_d         = '0;
          marker_d      = 1'b0;
          len_hi_d      = 1'b0;
          len_done_d    = 1'b0;
          pad_pending_d = 1'b0;
          state_d       = ST_FILL;
        end
      end

      ST_FILL: begin
        if (valid_i && ready_o) begin
          blk_d[idx_q[3:0]] = fill_word;
          cnt_d             = cnt_q + {58'h0, bytes_i, 3'b000};
          idx_d             = idx_q + 5'd1;
          if (last_i) begin
            marker_d = (bytes_i < 3'd4);
            state_d  = ST_PAD;
          end else if (idx_q == 5'd15) begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_PAD: begin
        if (idx_q == 5'd16) begin
          // Length did not fit; it goes into a follow-up pad-only block.
          pad_pending_d = 1'b1;
          state_d       = ST_LOAD;
        end else if (!marker_q) begin
          blk_d[idx_q[3:0]] = 32'h8000_0000;
          marker_d          = 1'b1;
          idx_d             = idx_q + 5'd1;
        end else if (idx_q == 5'd14) begin
          blk_d[14] = cnt_q[63:32];
          len_hi_d  = 1'b1;
          idx_d     = idx_q + 5'd1;
        end else if (idx_q == 5'd15 && len_hi_q) begin
          blk_d[15]  = cnt_q[31:0];
          len_done_d = 1'b1;
          idx_d      = idx_q + 5'd1;
          state_d    = ST_LOAD;
        end else begin
          blk_d[idx_q[3:0]] = 32'h0;
          idx_d             = idx_q + 5'd1;
        end
      end

      ST_LOAD: begin
        if (core_busy_i) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (!core_busy_i) begin
          chain_d = core_state_i;
          idx_d   = '0;
          if (len_done_q) begin
            digest_d = final_digest;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else if (pad_pending_q) begin
            blk_d         = '{default: '0};
            pad_pending_d = 1'b0;
            state_d       = ST_PAD;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the block buffer is reset too, because core_data_o must read zero
  // out of reset; it is small enough to live in flops.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      for (int i = 0; i < 16; i++) blk_q[i] <= '0;
      chain_q       <= '0;
      digest_q      <= '0;
      cnt_q         <= '0;
      marker_q      <= 1'b0;
      len_hi_q      <= 1'b0;
      len_done_q    <= 1'b0;
      pad_pending_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge _d values.
      state_q       <= state_d;
      idx_q         <= idx_d;
      blk_q         <= blk_d;
      chain_q       <= chain_d;
      digest_q      <= digest_d;
      cnt_q         <= cnt_d;
      marker_q      <= marker_d;
      len_hi_q      <= len_hi_d;
      len_done_q    <= len_done_d;
      pad_pending_q <= pad_pending_d;
      done_q        <= done_d;
    end
  end

endmodule
